// File: rtl/exc_commit_ctrl_pkg.sv
// Shared exception codes, flag bit positions and types for the WB exception/ERET commit controller.
package exc_commit_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] NO_EX    = 5'h1f;

    // Bit positions inside ws_ex_flags = {adel_if, ri, ov, sys, bp, adel_d, ades_d}
    localparam int FLAG_ADEL_IF = 6;
    localparam int FLAG_RI      = 5;
    localparam int FLAG_OV      = 4;
    localparam int FLAG_SYS     = 3;
    localparam int FLAG_BP      = 2;
    localparam int FLAG_ADEL_D  = 1;
    localparam int FLAG_ADES_D  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Pure combinational exception priority encoder: flags + pending interrupt -> taken code and side info.
module exc_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic [6:0]  flags,
    input  logic        int_pend,
    input  logic [31:0] pc,
    input  logic [31:0] mem_addr,
    output logic        taken,
    output logic [4:0]  ex_code,
    output logic        pc_error,
    output logic [31:0] badvaddr
);

    always_comb begin
        // NOTE: all outputs get a default before the priority chain so no path can infer a latch.
        taken    = 1'b1;
        ex_code  = NO_EX;
        pc_error = 1'b0;
        badvaddr = 32'h0;
        if (int_pend) begin
            ex_code = EXC_INT;
        end else if (flags[FLAG_ADEL_IF]) begin
            ex_code  = EXC_ADEL;
            pc_error = 1'b1;
            badvaddr = pc;
        end else if (flags[FLAG_RI]) begin
            ex_code = EXC_RI;
        end else if (flags[FLAG_OV]) begin
            ex_code = EXC_OV;
        end else if (flags[FLAG_SYS]) begin
            ex_code = EXC_SYS;
        end else if (flags[FLAG_BP]) begin
            ex_code = EXC_BP;
        end else if (flags[FLAG_ADEL_D]) begin
            ex_code  = EXC_ADEL;
            badvaddr = mem_addr;
        end else if (flags[FLAG_ADES_D]) begin
            ex_code  = EXC_ADES;
            badvaddr = mem_addr;
        end else begin
            taken = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/ERET commit controller: CP0 strobes, pipeline flush, redirect handshake to fetch.
// Optional macro EXC_STATS_EN adds exc_count/eret_count statistics outputs.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] VEC_BEV1     = 32'hbfc00380,
    parameter logic [31:0] VEC_BEV0     = 32'h80000180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic [6:0]  ws_ex_flags,
    input  logic        ws_eret,
    input  logic [31:0] ws_mem_addr,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  ex_code,
    output logic        slot,
    output logic        eret,
    output logic [31:0] badvaddr,
    output logic        pc_error,
    output logic [31:0] cp0_wdata,
    output logic        ws_allowin,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
`ifdef EXC_STATS_EN
    ,
    output logic [31:0] exc_count,
    output logic [15:0] eret_count
`endif
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   flush_cnt;
    logic            int_pend;
    logic            commit;
    logic            exc_take;
    logic            enc_taken;
    logic [4:0]      enc_code;
    logic            enc_pc_error;
    logic [31:0]     enc_badvaddr;
    logic [31:0]     target;
    logic            unused_bits;

    assign int_pend = (|(cp0_cause[15:8] & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];
    assign unused_bits = ^{cp0_cause[31:16], cp0_cause[7:0],
                           cp0_status[31:23], cp0_status[21:16], cp0_status[7:2]};

    exc_prio_enc u_prio (
        .flags    (ws_ex_flags),
        .int_pend (int_pend),
        .pc       (ws_pc),
        .mem_addr (ws_mem_addr),
        .taken    (enc_taken),
        .ex_code  (enc_code),
        .pc_error (enc_pc_error),
        .badvaddr (enc_badvaddr)
    );

    // Only an IDLE controller with a valid WB instruction may tag anything; otherwise CP0 sees idle strobes.
    assign commit   = (state == ST_IDLE) & ws_valid & ((|ws_ex_flags) | int_pend | ws_eret);
    assign exc_take = commit & enc_taken;

    assign ex_code   = exc_take ? enc_code : NO_EX;
    assign slot      = exc_take & ws_bd;
    assign eret      = commit & ws_eret & ~enc_taken;
    assign badvaddr  = exc_take ? enc_badvaddr : 32'h0;
    assign pc_error  = exc_take & enc_pc_error;
    assign cp0_wdata = exc_take ? ws_pc : 32'h0;
    assign target    = exc_take ? (cp0_status[22] ? VEC_BEV1 : VEC_BEV0) : cp0_epc;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt   <= '0;
            redirect_pc <= 32'h0;
        end else if (commit) begin
            flush_cnt   <= CW'(FLUSH_CYCLES - 1);
            redirect_pc <= target;
        end else if ((state == ST_FLUSH) && (flush_cnt != '0)) begin
            flush_cnt   <= flush_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        ws_allowin     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ws_allowin = 1'b1;
                if (commit) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt == '0) state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                if (redirect_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef EXC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_count  <= 32'h0;
            eret_count <= 16'h0;
        end else begin
            if (exc_take) exc_count  <= exc_count + 32'd1;
            if (eret)     eret_count <= eret_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_exc_commit_ctrl;

    localparam int unsigned FC      = 3;
    localparam logic [31:0] V_BEV1  = 32'hbfc00380;
    localparam logic [31:0] V_BEV0  = 32'h80000180;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_bd, ws_eret, redirect_ready;
    logic [31:0] ws_pc, ws_mem_addr, cp0_cause, cp0_status, cp0_epc;
    logic [6:0]  ws_ex_flags;
    logic [4:0]  ex_code;
    logic        slot, eret, pc_error, ws_allowin, flush, redirect_valid;
    logic [31:0] badvaddr, cp0_wdata, redirect_pc;
`ifdef EXC_STATS_EN
    logic [31:0] exc_count;
    logic [15:0] eret_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: remaining flush cycles, outstanding redirect, latched target, statistics.
    int          m_flush_left = 0;
    bit          m_redir      = 1'b0;
    logic [31:0] m_target     = 32'h0;
    logic [31:0] m_exc_cnt    = 32'h0;
    logic [15:0] m_eret_cnt   = 16'h0;

    // Exception code per flag bit, bit 0 (ades_d) .. bit 6 (adel_if)
    logic [4:0] code_of_bit [7] = '{5'd5, 5'd4, 5'd9, 5'd8, 5'd12, 5'd10, 5'd4};

    always #5 clk = ~clk;

    exc_commit_ctrl #(.FLUSH_CYCLES(FC), .VEC_BEV1(V_BEV1), .VEC_BEV0(V_BEV0)) dut (
        .clk            (clk),
        .reset          (reset),
        .ws_valid       (ws_valid),
        .ws_pc          (ws_pc),
        .ws_bd          (ws_bd),
        .ws_ex_flags    (ws_ex_flags),
        .ws_eret        (ws_eret),
        .ws_mem_addr    (ws_mem_addr),
        .cp0_cause      (cp0_cause),
        .cp0_status     (cp0_status),
        .cp0_epc        (cp0_epc),
        .ex_code        (ex_code),
        .slot           (slot),
        .eret           (eret),
        .badvaddr       (badvaddr),
        .pc_error       (pc_error),
        .cp0_wdata      (cp0_wdata),
        .ws_allowin     (ws_allowin),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
`ifdef EXC_STATS_EN
        ,
        .exc_count      (exc_count),
        .eret_count     (eret_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model, clock once, then advance the model.
    task automatic tick();
        bit          idle, ip, is_commit, is_exc, is_eret;
        int          sel;
        logic [4:0]  e_code;
        logic [31:0] e_bad;
        #1;
        idle      = (m_flush_left == 0) && !m_redir;
        ip        = ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h0) && cp0_status[0] && !cp0_status[1];
        is_commit = idle && ws_valid && (ws_ex_flags != 7'h0 || ip || ws_eret);
        sel       = -1;
        for (int b = 6; b >= 0; b--)
            if (sel < 0 && ws_ex_flags[b]) sel = b;
        is_exc  = is_commit && (ip || sel >= 0);
        is_eret = is_commit && !is_exc;
        e_code  = !is_exc ? 5'h1f : (ip ? 5'd0 : code_of_bit[sel]);
        e_bad   = 32'h0;
        if (is_exc && !ip && sel == 6) e_bad = ws_pc;
        if (is_exc && !ip && (sel == 1 || sel == 0)) e_bad = ws_mem_addr;

        check("ex_code",        32'(ex_code),        32'(e_code));
        check("slot",           32'(slot),           32'(is_exc && ws_bd));
        check("eret",           32'(eret),           32'(is_eret));
        check("badvaddr",       badvaddr,            e_bad);
        check("pc_error",       32'(pc_error),       32'(is_exc && !ip && sel == 6));
        check("cp0_wdata",      cp0_wdata,           is_exc ? ws_pc : 32'h0);
        check("ws_allowin",     32'(ws_allowin),     32'(idle));
        check("flush",          32'(flush),          32'(m_flush_left > 0));
        check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        check("redirect_pc",    redirect_pc,         m_target);
`ifdef EXC_STATS_EN
        check("exc_count",      exc_count,           m_exc_cnt);
        check("eret_count",     32'(eret_count),     32'(m_eret_cnt));
`endif

        @(posedge clk);
        if (reset) begin
            m_flush_left = 0;
            m_redir      = 1'b0;
            m_target     = 32'h0;
            m_exc_cnt    = 32'h0;
            m_eret_cnt   = 16'h0;
        end else begin
            if (is_commit) begin
                m_flush_left = FC;
                m_target     = is_exc ? (cp0_status[22] ? V_BEV1 : V_BEV0) : cp0_epc;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) m_redir = 1'b1;
            end else if (m_redir && redirect_ready) begin
                m_redir = 1'b0;
            end
            if (is_exc)  m_exc_cnt  = m_exc_cnt + 32'd1;
            if (is_eret) m_eret_cnt = m_eret_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        ws_valid       = 1'b0;
        ws_pc          = 32'h0;
        ws_bd          = 1'b0;
        ws_ex_flags    = 7'h0;
        ws_eret        = 1'b0;
        ws_mem_addr    = 32'h0;
        cp0_cause      = 32'h0;
        cp0_status     = 32'h0040_0000;
        cp0_epc        = 32'h0;
        redirect_ready = 1'b1;
    endtask

    task automatic drain();
        ws_valid       = 1'b0;
        ws_ex_flags    = 7'h0;
        ws_eret        = 1'b0;
        redirect_ready = 1'b1;
        repeat (FC + 3) tick();
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        #1;
        check("rst_allowin", 32'(ws_allowin), 32'd1);
        check("rst_ex_code", 32'(ex_code), 32'h1f);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Reset while a redirect is outstanding drops it
        ws_valid = 1'b1; ws_ex_flags = 7'b0001000; ws_pc = 32'h8000_0040; redirect_ready = 1'b0;
        tick();
        ws_valid = 1'b0; ws_ex_flags = 7'h0;
        repeat (FC) tick();
        #1 check("pre_rst_redir_valid", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_redir_valid", 32'(redirect_valid), 32'd0);
        check("post_rst_allowin", 32'(ws_allowin), 32'd1);
        redirect_ready = 1'b1;
        repeat (4) begin
            #1 check("no_stale_redirect", 32'(redirect_valid), 32'd0);
            tick();
        end

        // RI with BEV=1
        ws_valid = 1'b1; ws_ex_flags = 7'b0100000; cp0_status = 32'h0040_0000; ws_pc = 32'hbfc0_0100;
        #1 check("ri_ex_code", 32'(ex_code), 32'd10);
        tick();
        ws_valid = 1'b0; ws_ex_flags = 7'h0;
        repeat (FC) begin
            #1 check("ri_flush", 32'(flush), 32'd1);
            tick();
        end
        #1;
        check("ri_redir_valid", 32'(redirect_valid), 32'd1);
        check("ri_redir_pc", redirect_pc, 32'hbfc0_0380);
        tick();
        #1 check("ri_back_idle", 32'(ws_allowin), 32'd1);

        // Fetch address error in a delay slot
        ws_valid = 1'b1; ws_ex_flags = 7'b1000000; ws_bd = 1'b1; ws_pc = 32'hbfc0_0203;
        #1;
        check("adel_if_code", 32'(ex_code), 32'd4);
        check("adel_if_pc_error", 32'(pc_error), 32'd1);
        check("adel_if_slot", 32'(slot), 32'd1);
        check("adel_if_badvaddr", badvaddr, 32'hbfc0_0203);
        tick();
        ws_bd = 1'b0;
        drain();

        // ERET with fetch stalling the redirect
        ws_valid = 1'b1; ws_eret = 1'b1; cp0_epc = 32'h8000_1000; redirect_ready = 1'b0;
        #1;
        check("eret_pulse", 32'(eret), 32'd1);
        check("eret_no_ex", 32'(ex_code), 32'h1f);
        tick();
        ws_valid = 1'b0; ws_eret = 1'b0;
        #1 check("eret_single_cycle", 32'(eret), 32'd0);
        repeat (FC) tick();
        repeat (3) begin
            #1;
            check("eret_redir_held", 32'(redirect_valid), 32'd1);
            check("eret_redir_pc", redirect_pc, 32'h8000_1000);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        #1 check("eret_done", 32'(redirect_valid), 32'd0);

        // Interrupt beats overflow
        ws_valid = 1'b1; ws_ex_flags = 7'b0010000; ws_pc = 32'h8000_2000;
        cp0_cause = 32'h0000_8000; cp0_status = 32'h0000_8001;
        #1;
        check("int_code", 32'(ex_code), 32'd0);
        check("int_wdata", cp0_wdata, 32'h8000_2000);
        tick();
        drain();
`ifdef EXC_STATS_EN
        #1;
        check("stats_exc", exc_count, 32'd3);
        check("stats_eret", 32'(eret_count), 32'd1);
`endif
        // EXL masks the interrupt
        ws_valid = 1'b1; ws_ex_flags = 7'b0010000; cp0_status = 32'h0000_8003;
        #1 check("exl_ov_code", 32'(ex_code), 32'd12);
        tick();
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(99) == 0);
            ws_valid       = ($urandom_range(3) != 0);
            ws_pc          = $urandom;
            ws_bd          = $urandom_range(1);
            ws_mem_addr    = $urandom;
            ws_ex_flags    = ($urandom_range(2) == 0) ? 7'($urandom) :
                             (($urandom_range(2) == 0) ? 7'(1 << $urandom_range(6)) : 7'h0);
            ws_eret        = ($urandom_range(5) == 0);
            cp0_cause      = $urandom & 32'h0000_ff00;
            cp0_status     = ($urandom & 32'h0040_ff03) & (($urandom_range(3) == 0) ? 32'hffff_ffff : 32'hffff_00ff);
            cp0_epc        = $urandom;
            redirect_ready = $urandom_range(1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
